// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - initiator-side controller for the shared 16-bit instruction/data memory port
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   core_i_*          - fetch request/ack from the core, fetched word and completion pulse back
//   core_d_*          - load/store request/ack from the core, loaded word and completion pulse back
//   busy              - controller is sequencing an operation (not IDLE)
//   i_read, i_push    - memory instruction read strobe / memory drives fetched word on d_bus
//   d_read, d_push    - memory data read strobe / memory drives loaded word on d_bus
//   d_write           - memory data write strobe; controller drives d_bus in this cycle
//   i_addr, d_addr    - latched memory addresses, stable for the whole operation
//   d_bus             - shared tristate data bus
module mem_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_i_req,
    input  logic [ADDR_W-1:0] core_i_addr,
    output logic              core_i_ack,
    output logic              core_i_valid,
    output logic [DATA_W-1:0] core_i_data,
    input  logic              core_d_req,
    input  logic              core_d_we,
    input  logic [ADDR_W-1:0] core_d_addr,
    input  logic [DATA_W-1:0] core_d_wdata,
    output logic              core_d_ack,
    output logic              core_d_valid,
    output logic [DATA_W-1:0] core_d_data,
    output logic              busy,
    output logic              i_read,
    output logic              i_push,
    output logic              d_read,
    output logic              d_write,
    output logic              d_push,
    output logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] d_addr,
    inout  wire  [DATA_W-1:0] d_bus
);

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        I_PUSH,
        D_READ,
        D_PUSH,
        D_WRITE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] i_addr_r;
    logic [ADDR_W-1:0] d_addr_r;
    logic [DATA_W-1:0] wdata_r;

    // Data requests win over fetches when both arrive in the same IDLE cycle.
    assign core_d_ack = (state == IDLE) && core_d_req;
    assign core_i_ack = (state == IDLE) && core_i_req && !core_d_req;

    // Strobes are pure state decodes, so at most one can ever be high.
    assign i_read  = (state == I_READ);
    assign i_push  = (state == I_PUSH);
    assign d_read  = (state == D_READ);
    assign d_push  = (state == D_PUSH);
    assign d_write = (state == D_WRITE);
    assign busy    = (state != IDLE);

    assign i_addr = i_addr_r;
    assign d_addr = d_addr_r;

    // Controller owns the bus only while the memory is writing.
    assign d_bus = (state == D_WRITE) ? wdata_r : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            i_addr_r     <= '0;
            d_addr_r     <= '0;
            wdata_r      <= '0;
            core_i_valid <= 1'b0;
            core_d_valid <= 1'b0;
            core_i_data  <= '0;
            core_d_data  <= '0;
        end else begin
            core_i_valid <= 1'b0;
            core_d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_d_ack) begin
                        d_addr_r <= core_d_addr;
                        wdata_r  <= core_d_wdata;
                        state    <= core_d_we ? D_WRITE : D_READ;
                    end else if (core_i_ack) begin
                        i_addr_r <= core_i_addr;
                        state    <= I_READ;
                    end
                end
                I_READ: state <= I_PUSH;
                I_PUSH: begin
                    core_i_data  <= d_bus;
                    core_i_valid <= 1'b1;
                    state        <= IDLE;
                end
                D_READ: state <= D_PUSH;
                D_PUSH: begin
                    core_d_data  <= d_bus;
                    core_d_valid <= 1'b1;
                    state        <= IDLE;
                end
                D_WRITE: begin
                    // Store completion; core_d_data keeps the last loaded word.
                    core_d_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a behavioural memory on d_bus
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_i_req = 1'b0;
    logic [15:0] core_i_addr = '0;
    logic        core_i_ack;
    logic        core_i_valid;
    logic [15:0] core_i_data;
    logic        core_d_req = 1'b0;
    logic        core_d_we = 1'b0;
    logic [15:0] core_d_addr = '0;
    logic [15:0] core_d_wdata = '0;
    logic        core_d_ack;
    logic        core_d_valid;
    logic [15:0] core_d_data;
    logic        busy;
    logic        i_read, i_push, d_read, d_write, d_push;
    logic [15:0] i_addr, d_addr;
    tri0  [15:0] d_bus;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
        logic        chk_data;
    } exp_t;

    exp_t i_q[$];
    exp_t d_q[$];
    exp_t e_i, e_d;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .core_i_req(core_i_req), .core_i_addr(core_i_addr), .core_i_ack(core_i_ack),
        .core_i_valid(core_i_valid), .core_i_data(core_i_data),
        .core_d_req(core_d_req), .core_d_we(core_d_we), .core_d_addr(core_d_addr),
        .core_d_wdata(core_d_wdata), .core_d_ack(core_d_ack),
        .core_d_valid(core_d_valid), .core_d_data(core_d_data),
        .busy(busy), .i_read(i_read), .i_push(i_push), .d_read(d_read),
        .d_write(d_write), .d_push(d_push), .i_addr(i_addr), .d_addr(d_addr),
        .d_bus(d_bus)
    );

    // Behavioural memory: drives d_bus during push cycles, writes at end of d_write cycle.
    assign d_bus = i_push ? mem[i_addr[7:0]] : (d_push ? mem[d_addr[7:0]] : 16'hzzzz);

    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 16'hA000;
            mem[8'h11] <= 16'hA001;
            mem[8'h12] <= 16'hA002;
            mem[8'h20] <= 16'hBEEF;
        end else if (d_write) begin
            mem[d_addr[7:0]] <= d_bus;
        end
    end

    // Scoreboard and continuous bus checks.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_i_valid) begin
                tests_run++;
                if (i_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL i_valid_unexpected: core_i_valid=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e_i = i_q.pop_front();
                    if (core_i_data !== e_i.data || cyc != e_i.due) begin
                        tests_failed++;
                        $display("FAIL i_valid: data=%h cycle=%0d, required data=%h cycle=%0d",
                                 core_i_data, cyc, e_i.data, e_i.due);
                    end
                end
            end
            if (core_d_valid) begin
                tests_run++;
                if (d_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL d_valid_unexpected: core_d_valid=1 at cycle %0d, required no pulse", cyc);
                end else begin
                    e_d = d_q.pop_front();
                    if ((e_d.chk_data && core_d_data !== e_d.data) || cyc != e_d.due) begin
                        tests_failed++;
                        $display("FAIL d_valid: data=%h cycle=%0d, required data=%h cycle=%0d",
                                 core_d_data, cyc, e_d.data, e_d.due);
                    end
                end
            end
            tests_run++;
            if ($countones({i_read, i_push, d_read, d_write, d_push}) > 1) begin
                tests_failed++;
                $display("FAIL strobe_onehot: strobes=%b at cycle %0d, required at most one high",
                         {i_read, i_push, d_read, d_write, d_push}, cyc);
            end
            // With nothing driving, the pulled-down bus reads 0.
            if (!i_push && !d_push && !d_write) begin
                tests_run++;
                if (d_bus !== 16'h0000) begin
                    tests_failed++;
                    $display("FAIL d_bus_released: d_bus=%h at cycle %0d, required undriven (0)", d_bus, cyc);
                end
            end
        end
    end

    task automatic fail_if(input logic bad, input string name, input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic issue_fetch(input logic [15:0] a, input logic [15:0] exp, output int ack_cyc);
        core_i_req  = 1'b1;
        core_i_addr = a;
        ack_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (core_i_ack) begin
                ack_cyc = cyc;
                i_q.push_back('{exp, cyc + 3, 1'b1});
                break;
            end
            @(negedge clk);
        end
        fail_if(ack_cyc < 0, "fetch_ack_timeout", 16'h0, 16'h1);
        @(negedge clk);
    endtask

    task automatic issue_data(input logic we, input logic [15:0] a, input logic [15:0] wd,
                              input logic [15:0] exp, output int ack_cyc);
        core_d_req   = 1'b1;
        core_d_we    = we;
        core_d_addr  = a;
        core_d_wdata = wd;
        ack_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (core_d_ack) begin
                ack_cyc = cyc;
                d_q.push_back('{exp, cyc + (we ? 2 : 3), !we});
                break;
            end
            @(negedge clk);
        end
        fail_if(ack_cyc < 0, "data_ack_timeout", 16'h0, 16'h1);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (i_q.size() == 0 && d_q.size() == 0) break;
            @(negedge clk);
        end
        fail_if(i_q.size() != 0 || d_q.size() != 0, "valid_missing",
                16'(i_q.size() + d_q.size()), 16'h0);
        i_q.delete();
        d_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        fail_if(busy !== 1'b0, "reset_busy", 16'(busy), 16'h0);
        fail_if({i_read, i_push, d_read, d_write, d_push} !== 5'b0, "reset_strobes",
                16'({i_read, i_push, d_read, d_write, d_push}), 16'h0);
        fail_if({core_i_valid, core_d_valid} !== 2'b0, "reset_valids",
                16'({core_i_valid, core_d_valid}), 16'h0);
        fail_if(core_i_data !== 16'h0, "reset_i_data", core_i_data, 16'h0);
        fail_if(core_d_data !== 16'h0, "reset_d_data", core_d_data, 16'h0);
        fail_if(i_addr !== 16'h0 || d_addr !== 16'h0, "reset_addr", i_addr | d_addr, 16'h0);
        fail_if(d_bus !== 16'h0, "reset_d_bus", d_bus, 16'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n;
        issue_fetch(16'h0010, 16'hA000, n);
        core_i_req = 1'b0;
        fail_if(i_read !== 1'b1 || busy !== 1'b1, "fetch_cycle1_i_read_busy", 16'({i_read, busy}), 16'h3);
        fail_if(i_addr !== 16'h0010, "fetch_i_addr", i_addr, 16'h0010);
        @(negedge clk);
        fail_if(i_push !== 1'b1 || busy !== 1'b1, "fetch_cycle2_i_push_busy", 16'({i_push, busy}), 16'h3);
        @(negedge clk);
        fail_if(busy !== 1'b0, "fetch_cycle3_idle", 16'(busy), 16'h0);
        drain();
    endtask

    task automatic test_store_load();
        int n;
        issue_data(1'b1, 16'h0040, 16'h1234, 16'h0, n);
        core_d_req = 1'b0;
        fail_if(d_write !== 1'b1, "store_d_write", 16'(d_write), 16'h1);
        fail_if(d_bus !== 16'h1234, "store_d_bus", d_bus, 16'h1234);
        fail_if(d_addr !== 16'h0040, "store_d_addr", d_addr, 16'h0040);
        @(negedge clk);
        fail_if(d_write !== 1'b0, "store_single_cycle", 16'(d_write), 16'h0);
        drain();
        issue_data(1'b0, 16'h0040, 16'h0, 16'h1234, n);
        core_d_req = 1'b0;
        drain();
    endtask

    task automatic test_priority();
        int nd, ni;
        core_i_req  = 1'b1;
        core_i_addr = 16'h0010;
        core_d_req  = 1'b1;
        core_d_we   = 1'b0;
        core_d_addr = 16'h0020;
        #1;
        fail_if(core_d_ack !== 1'b1, "prio_d_ack", 16'(core_d_ack), 16'h1);
        fail_if(core_i_ack !== 1'b0, "prio_i_blocked", 16'(core_i_ack), 16'h0);
        nd = cyc;
        if (core_d_ack) d_q.push_back('{16'hBEEF, cyc + 3, 1'b1});
        @(negedge clk);
        core_d_req = 1'b0;
        issue_fetch(16'h0010, 16'hA000, ni);
        core_i_req = 1'b0;
        fail_if(ni != nd + 3, "prio_fetch_ack_cycle", 16'(ni - nd), 16'h3);
        drain();
    endtask

    task automatic test_back_to_back();
        int n0, n1, n2;
        issue_fetch(16'h0010, 16'hA000, n0);
        issue_fetch(16'h0011, 16'hA001, n1);
        issue_fetch(16'h0012, 16'hA002, n2);
        core_i_req = 1'b0;
        fail_if(n1 - n0 != 3 || n2 - n1 != 3, "b2b_spacing", 16'((n1 - n0) * 16 + (n2 - n1)), 16'h33);
        drain();
    endtask

    task automatic test_mid_reset();
        int n;
        issue_fetch(16'h0010, 16'hA000, n);
        core_i_req = 1'b0;
        @(negedge clk);
        fail_if(i_push !== 1'b1, "midrst_in_i_push", 16'(i_push), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        i_q.delete();
        fail_if({i_read, i_push, d_read, d_write, d_push} !== 5'b0, "midrst_strobes",
                16'({i_read, i_push, d_read, d_write, d_push}), 16'h0);
        fail_if(busy !== 1'b0, "midrst_busy", 16'(busy), 16'h0);
        fail_if(core_i_valid !== 1'b0, "midrst_no_valid", 16'(core_i_valid), 16'h0);
        fail_if(core_i_data !== 16'h0, "midrst_i_data", core_i_data, 16'h0);
        fail_if(d_bus !== 16'h0, "midrst_d_bus", d_bus, 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue_fetch(16'h0011, 16'hA001, n);
        core_i_req = 1'b0;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
